// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a host byte stream big-endian into 32-bit words,
// screens each word's opcode, writes legal words and holds the CPU in reset meanwhile.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_reg;
  logic [ADDR_W:0] word_cnt_reg;
  logic [ADDR_W:0] len_reg;
  logic [1:0]      byte_cnt_reg;
  logic [23:0]     word_reg;
  logic            len_ok;
  logic            accept;

  // Opcodes the main control decoder implements.
  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      6'd20, 6'd43, 6'd35, 6'd8, 6'd9, 6'd4, 6'd2: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  assign len_ok   = (len != '0) && (len <= CAP);
  assign accept   = in_valid && in_ready;
  assign cpu_hold = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      word_cnt_reg <= '0;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      word_reg     <= '0;
      in_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_addr     <= '0;
    end else begin
      done    <= 1'b0;
      imem_we <= 1'b0;
      case (state_reg)
        IDLE, ERR: begin
          if (start) begin
            if (len_ok) begin
              state_reg    <= RECV;
              len_reg      <= len;
              word_cnt_reg <= '0;
              byte_cnt_reg <= '0;
              err          <= 1'b0;
              busy         <= 1'b1;
              in_ready     <= 1'b1;
            end else begin
              state_reg <= ERR;
              err       <= 1'b1;
              err_addr  <= '0;
            end
          end
        end
        RECV: begin
          if (accept) begin
            // Shift in MSB-first; after four bytes the first byte sits in [31:24].
            word_reg     <= {word_reg[15:0], in_data};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              state_reg  <= WRITE;
              in_ready   <= 1'b0;
              imem_we    <= opcode_legal(word_reg[23:18]);
              imem_wdata <= {word_reg, in_data};
              imem_addr  <= word_cnt_reg[ADDR_W-1:0];
            end
          end
        end
        WRITE: begin
          byte_cnt_reg <= '0;
          if (opcode_legal(imem_wdata[31:26])) begin
            word_cnt_reg <= word_cnt_reg + ONE;
            if (word_cnt_reg + ONE == len_reg) begin
              state_reg <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state_reg <= RECV;
              in_ready  <= 1'b1;
            end
          end else begin
            state_reg <= ERR;
            err       <= 1'b1;
            err_addr  <= word_cnt_reg[ADDR_W-1:0];
            busy      <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: host byte feeder, write monitor, hand-computed expectations.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready, imem_we, busy, cpu_hold, done, err;
  logic [ADDR_W-1:0] imem_addr, err_addr;
  logic [31:0]       imem_wdata;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done),
    .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int hold_bad = 0;
  int done_cyc = -1;
  int last_wr_cyc = -1;
  logic [7:0]        tx_q[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cnt++;
    if (cpu_hold !== busy) hold_bad++;
    if (done) done_cyc = cyc;
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      last_wr_cyc = cyc;
      $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    busy_cnt = 0;
    done_cyc = -1;
    last_wr_cyc = -1;
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[31:24]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns #1 after the edge that sampled start, i.e. in cycle T+1.
  task automatic do_start(input logic [ADDR_W:0] l);
    @(posedge clk); #1;
    start = 1'b1; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends n bytes from tx_q; with gap set, in_valid drops every other cycle.
  task automatic send(input int n, input bit gap);
    int sent = 0;
    int budget = 400;
    bit phase = 1'b0;
    bit acc;
    while (sent < n && budget > 0) begin
      in_valid = gap ? ~phase : 1'b1;
      in_data  = tx_q[0];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      phase = ~phase;
      budget--;
      if (acc) begin
        void'(tx_q.pop_front());
        sent++;
      end
    end
    in_valid = 1'b0;
    if (sent < n) check("send_timeout", 64'(sent), 64'(n));
  endtask

  task automatic wait_done();
    int budget = 50;
    int d0 = done_cyc;
    while (done_cyc == d0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (done_cyc == d0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    do_reset();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_imem_we",  imem_we, 1'b0);
    check("rst_busy",     busy, 1'b0);
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_done",     done, 1'b0);
    check("rst_err",      err, 1'b0);
    check("rst_addr",     imem_addr, '0);
    check("rst_wdata",    imem_wdata, '0);
    check("rst_err_addr", err_addr, '0);

    // Two-word load with in_valid held high.
    clear_log();
    do_start(9'd2);
    check("t1_busy_T1",  busy, 1'b1);
    check("t1_ready_T1", in_ready, 1'b1);
    push_word(32'h8C220004);
    push_word(32'h20010005);
    send(8, 1'b0);
    wait_done();
    check("t1_nwr", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      check("t1_a0", wr_addr[0], 8'd0);
      check("t1_d0", wr_data[0], 32'h8C220004);
      check("t1_a1", wr_addr[1], 8'd1);
      check("t1_d1", wr_data[1], 32'h20010005);
    end
    check("t1_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);
    check("t1_busy_cyc", 64'(busy_cnt), 64'd10);
    idle(1);
    check("t1_done_pulse", done, 1'b0);
    check("t1_busy_after", busy, 1'b0);

    // Illegal opcode 63, then recovery with a legal word.
    clear_log();
    do_start(9'd1);
    push_word(32'hFC000000);
    send(4, 1'b0);
    idle(3);
    check("t2_nwr",      64'(wr_addr.size()), 64'd0);
    check("t2_err",      err, 1'b1);
    check("t2_err_addr", err_addr, 8'd0);
    check("t2_ready",    in_ready, 1'b0);
    check("t2_busy",     busy, 1'b0);
    do_start(9'd1);
    check("t2_err_clr", err, 1'b0);
    push_word(32'h08000001);
    send(4, 1'b0);
    wait_done();
    check("t2_nwr2", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) begin
      check("t2_a0", wr_addr[0], 8'd0);
      check("t2_d0", wr_data[0], 32'h08000001);
    end

    // Out-of-range lengths.
    do_reset();
    clear_log();
    do_start(9'd0);
    check("t3_len0_err",  err, 1'b1);
    check("t3_len0_eadr", err_addr, 8'd0);
    idle(2);
    check("t3_len0_busy", 64'(busy_cnt), 64'd0);
    do_reset();
    clear_log();
    do_start(9'd257);
    check("t3_len257_err", err, 1'b1);
    idle(2);
    check("t3_len257_busy", 64'(busy_cnt), 64'd0);

    // Three words with in_valid toggling.
    clear_log();
    do_start(9'd3);
    push_word(32'h8C220004);
    push_word(32'h20010005);
    push_word(32'hAC430008);
    send(12, 1'b1);
    wait_done();
    check("t4_nwr", 64'(wr_addr.size()), 64'd3);
    if (wr_addr.size() == 3) begin
      check("t4_a0", wr_addr[0], 8'd0);
      check("t4_d0", wr_data[0], 32'h8C220004);
      check("t4_a1", wr_addr[1], 8'd1);
      check("t4_d1", wr_data[1], 32'h20010005);
      check("t4_a2", wr_addr[2], 8'd2);
      check("t4_d2", wr_data[2], 32'hAC430008);
    end

    // Reset mid-load after two bytes of the second word.
    clear_log();
    do_start(9'd2);
    push_word(32'h8C220004);
    push_word(32'h20010005);
    send(6, 1'b0);
    tx_q.delete();
    do_reset();
    check("t5_busy",  busy, 1'b0);
    check("t5_hold",  cpu_hold, 1'b0);
    check("t5_ready", in_ready, 1'b0);
    check("t5_we",    imem_we, 1'b0);
    check("t5_nwr",   64'(wr_addr.size()), 64'd1);
    clear_log();
    do_start(9'd1);
    push_word(32'h24000007);
    send(4, 1'b0);
    wait_done();
    check("t5_nwr2", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) begin
      check("t5_a0", wr_addr[0], 8'd0);
      check("t5_d0", wr_data[0], 32'h24000007);
    end

    // start during RECV is ignored.
    clear_log();
    do_start(9'd2);
    push_word(32'h10000003);
    push_word(32'h8C220004);
    send(2, 1'b0);
    start = 1'b1; len = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    send(6, 1'b0);
    wait_done();
    check("t6_nwr", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2) begin
      check("t6_d0", wr_data[0], 32'h10000003);
      check("t6_a1", wr_addr[1], 8'd1);
      check("t6_d1", wr_data[1], 32'h8C220004);
    end
    check("t6_hold_eq_busy", 64'(hold_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
